// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback controller: opcodes,
// instruction field positions, FSM state encoding and the ALU control bundle.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_LI  = 4'd8;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int RT_MSB  = 5;
  localparam int RT_LSB  = 3;
  localparam int SH_MSB  = 5;
  localparam int SH_LSB  = 2;
  localparam int IMM_MSB = 8;
  localparam int IMM_W   = 9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic       slt_sel;
    logic       main_sel;
    logic       sft_sel;
    logic       ryt_sft_sel;
    logic [1:0] op;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder: maps a 4-bit opcode onto the ALU select/op
// lines and flags whether the ALU is used and whether the opcode is illegal.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       slt_sel,
  output logic       main_sel,
  output logic       sft_sel,
  output logic       ryt_sft_sel,
  output logic [1:0] op,
  output logic       illegal,
  output logic       uses_alu
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    slt_sel     = 1'b0;
    main_sel    = 1'b0;
    sft_sel     = 1'b0;
    ryt_sft_sel = 1'b0;
    op          = 2'b00;
    illegal     = 1'b0;
    uses_alu    = 1'b1;
    case (opcode)
      OP_ADD: op = 2'b00;
      OP_SUB: op = 2'b01;
      OP_AND: op = 2'b10;
      OP_OR:  op = 2'b11;
      OP_SLT: slt_sel = 1'b1;
      OP_SLL: main_sel = 1'b1;
      OP_SRL: begin
        main_sel = 1'b1;
        sft_sel  = 1'b1;
      end
      OP_SRA: begin
        main_sel    = 1'b1;
        sft_sel     = 1'b1;
        ryt_sft_sel = 1'b1;
      end
      OP_LI:  uses_alu = 1'b0;
      default: begin
        illegal  = 1'b1;
        uses_alu = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 16-bit combinational ALU: accepts an
// instruction, drives the ALU for one EXEC cycle, writes back and responds.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        instr_valid,
  input  logic [15:0]                 instr,
  output logic                        instr_ready,
  output logic                        alu_slt_sel,
  output logic                        alu_main_sel,
  output logic                        alu_sft_sel,
  output logic                        alu_ryt_sft_sel,
  output logic [1:0]                  alu_op,
  output logic [3:0]                  alu_sft_op,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  input  logic [DATA_W-1:0]           alu_o,
  input  logic                        alu_cout,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [DATA_W-1:0]           resp_data,
  output logic [$clog2(RF_DEPTH)-1:0] resp_rd,
  output logic                        resp_cout,
  output logic                        resp_zero,
  output logic                        resp_err,
  input  logic [$clog2(RF_DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           dbg_data
);

  localparam int IDX_W = $clog2(RF_DEPTH);

  logic [1:0]        state_q;
  logic [DATA_W-1:0] rf [RF_DEPTH];

  alu_ctrl_t         ctrl_d;
  alu_ctrl_t         ctrl_q;
  logic              illegal_d;
  logic              uses_alu_d;
  logic              illegal_q;
  logic              uses_alu_q;
  logic              carry_q;
  logic [3:0]        shamt_q;
  logic [IDX_W-1:0]  rd_q;
  logic [IDX_W-1:0]  rs_q;
  logic [IDX_W-1:0]  rt_q;
  logic [IMM_W-1:0]  imm_q;

  logic [DATA_W-1:0] resp_data_q;
  logic [IDX_W-1:0]  resp_rd_q;
  logic              resp_cout_q;
  logic              resp_zero_q;
  logic              resp_err_q;

  logic              exec;
  logic              drive_operands;
  logic [DATA_W-1:0] wb_data;

  alu_ctrl_decode u_decode (
    .opcode      (instr[OPC_MSB:OPC_LSB]),
    .slt_sel     (ctrl_d.slt_sel),
    .main_sel    (ctrl_d.main_sel),
    .sft_sel     (ctrl_d.sft_sel),
    .ryt_sft_sel (ctrl_d.ryt_sft_sel),
    .op          (ctrl_d.op),
    .illegal     (illegal_d),
    .uses_alu    (uses_alu_d)
  );

  // Ready is also gated by reset so it reads 0 while rst_n is held low.
  assign instr_ready    = (state_q == ST_IDLE) && rst_n;
  assign resp_valid     = (state_q == ST_RESP);
  assign exec           = (state_q == ST_EXEC);
  assign drive_operands = exec && uses_alu_q;

  assign alu_slt_sel     = exec && ctrl_q.slt_sel;
  assign alu_main_sel    = exec && ctrl_q.main_sel;
  assign alu_sft_sel     = exec && ctrl_q.sft_sel;
  assign alu_ryt_sft_sel = exec && ctrl_q.ryt_sft_sel;
  assign alu_op          = exec ? ctrl_q.op : 2'b00;
  assign alu_sft_op      = exec ? shamt_q : 4'd0;
  assign alu_a           = drive_operands ? rf[rs_q] : '0;
  assign alu_b           = drive_operands ? rf[rt_q] : '0;

  always_comb begin
    wb_data = '0;
    if (illegal_q) begin
      wb_data = '0;
    end else if (uses_alu_q) begin
      wb_data = alu_o;
    end else begin
      wb_data = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      uses_alu_q  <= 1'b0;
      carry_q     <= 1'b0;
      shamt_q     <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      resp_data_q <= '0;
      resp_rd_q   <= '0;
      resp_cout_q <= 1'b0;
      resp_zero_q <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
            uses_alu_q <= uses_alu_d;
            carry_q    <= (instr[OPC_MSB:OPC_LSB] == OP_ADD) ||
                          (instr[OPC_MSB:OPC_LSB] == OP_SUB);
            shamt_q    <= ctrl_d.main_sel ? instr[SH_MSB:SH_LSB] : 4'd0;
            rd_q       <= instr[RD_MSB:RD_LSB];
            rs_q       <= instr[RS_MSB:RS_LSB];
            rt_q       <= instr[RT_MSB:RT_LSB];
            imm_q      <= instr[IMM_MSB:0];
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_data_q <= wb_data;
          resp_rd_q   <= rd_q;
          resp_cout_q <= carry_q && alu_cout;
          resp_zero_q <= (wb_data == '0);
          resp_err_q  <= illegal_q;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the register file is small and must read 0 after reset, so it is reset explicitly here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (exec && !illegal_q) begin
      rf[rd_q] <= wb_data;
    end
  end

  assign resp_data = resp_data_q;
  assign resp_rd   = resp_rd_q;
  assign resp_cout = resp_cout_q;
  assign resp_zero = resp_zero_q;
  assign resp_err  = resp_err_q;
  assign dbg_data  = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, register-file model
// and an in-order scoreboard of expected responses.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        alu_slt_sel, alu_main_sel, alu_sft_sel, alu_ryt_sft_sel;
  logic [1:0]  alu_op;
  logic [3:0]  alu_sft_op;
  logic [15:0] alu_a, alu_b, alu_o;
  logic        alu_cout;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_data;
  logic [2:0]  resp_rd;
  logic        resp_cout, resp_zero, resp_err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        cout;
    logic        zero;
    logic        err;
    logic        main;
    logic [3:0]  sft;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_rf[8];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_slt_sel(alu_slt_sel), .alu_main_sel(alu_main_sel),
    .alu_sft_sel(alu_sft_sel), .alu_ryt_sft_sel(alu_ryt_sft_sel), .alu_op(alu_op),
    .alu_sft_op(alu_sft_op), .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o),
    .alu_cout(alu_cout), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rd(resp_rd), .resp_cout(resp_cout),
    .resp_zero(resp_zero), .resp_err(resp_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU on the far side of the controller.
  logic [16:0] alu_w;
  logic [15:0] alu_df;
  always_comb begin
    alu_o    = '0;
    alu_cout = 1'b0;
    alu_w    = '0;
    alu_df   = alu_a - alu_b;
    if (alu_slt_sel) begin
      alu_o = {15'd0, alu_df[15]};
    end else if (alu_main_sel) begin
      if (!alu_sft_sel)         alu_o = alu_a << alu_sft_op;
      else if (!alu_ryt_sft_sel) alu_o = alu_a >> alu_sft_op;
      else                      alu_o = 16'($signed(alu_a) >>> alu_sft_op);
    end else begin
      case (alu_op)
        2'b00: alu_w = {1'b0, alu_a} + {1'b0, alu_b};
        2'b01: alu_w = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
        2'b10: alu_w = {1'b0, alu_a & alu_b};
        default: alu_w = {1'b0, alu_a | alu_b};
      endcase
      alu_o    = alu_w[15:0];
      alu_cout = alu_w[16];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] enc_s(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [3:0] sh);
    return {op, rd, rs, sh, 2'b00};
  endfunction

  function automatic logic [15:0] enc_li(input logic [2:0] rd, input logic [8:0] imm);
    return {4'h8, rd, imm};
  endfunction

  task automatic predict(input logic [15:0] ins);
    exp_t        e;
    logic [3:0]  op;
    logic [3:0]  sh;
    logic [15:0] a, b, df;
    logic [16:0] w;
    op     = ins[15:12];
    e.rd   = ins[11:9];
    sh     = ins[5:2];
    a      = model_rf[ins[8:6]];
    b      = model_rf[ins[5:3]];
    e.data = '0; e.cout = 1'b0; e.err = 1'b0; e.main = 1'b0; e.sft = '0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; e.data = w[15:0]; e.cout = w[16]; end
      4'd1: begin w = {1'b0, a} + {1'b0, ~b} + 17'd1; e.data = w[15:0]; e.cout = w[16]; end
      4'd2: e.data = a & b;
      4'd3: e.data = a | b;
      4'd4: begin df = a - b; e.data = {15'd0, df[15]}; end
      4'd5: begin e.main = 1'b1; e.sft = sh; e.data = a << sh; end
      4'd6: begin e.main = 1'b1; e.sft = sh; e.data = a >> sh; end
      4'd7: begin e.main = 1'b1; e.sft = sh; e.data = 16'($signed(a) >>> sh); end
      4'd8: e.data = {{7{ins[8]}}, ins[8:0]};
      default: e.err = 1'b1;
    endcase
    e.zero = (e.data == 16'd0);
    if (!e.err) model_rf[e.rd] = e.data;
    sb_q.push_back(e);
  endtask

  // Offers ins until the accepting edge; returns #1 after it (DUT in EXEC).
  task automatic accept(input logic [15:0] ins);
    int n;
    n = 0;
    instr       = ins;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  // Called in EXEC; holds resp_ready low for hold cycles, then completes the handshake.
  task automatic collect(input int hold);
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL sb_empty: no expected response queued");
      return;
    end
    e = sb_q[0];
    check("exec_no_resp", resp_valid, 0);
    check("exec_not_ready", instr_ready, 0);
    check("exec_main_sel", alu_main_sel, e.main);
    check("exec_sft_op", alu_sft_op, e.sft);
    @(posedge clk); #1;
    check("resp_latency", resp_valid, 1);
    check("resp_alu_quiet", {alu_slt_sel, alu_main_sel, alu_sft_sel, alu_ryt_sft_sel,
                             alu_op, alu_sft_op}, 0);
    e = sb_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      check("resp_data", resp_data, e.data);
      check("resp_rd", resp_rd, e.rd);
      check("resp_cout", resp_cout, e.cout);
      check("resp_zero", resp_zero, e.zero);
      check("resp_err", resp_err, e.err);
      if (i < hold) begin
        check("hold_valid", resp_valid, 1);
        check("hold_not_ready", instr_ready, 0);
        @(posedge clk); #1;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 0);
    check("idle_ready", instr_ready, 1);
  endtask

  task automatic check_reg(input logic [2:0] idx);
    dbg_addr = idx;
    @(negedge clk);
    check($sformatf("dbg_r%0d", idx), dbg_data, model_rf[idx]);
  endtask

  task automatic check_all_regs();
    for (int i = 0; i < 8; i++) check_reg(3'(i));
  endtask

  task automatic issue(input logic [15:0] ins);
    predict(ins);
    accept(ins);
    collect(0);
    check_reg(ins[11:9]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    instr_valid = 1'b0;
    instr       = '0;
    resp_ready  = 1'b0;
    dbg_addr    = '0;
    for (int i = 0; i < 8; i++) model_rf[i] = '0;

    // Reset state
    #1;
    check("rst_instr_ready", instr_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_bits", {resp_data, resp_rd, resp_cout, resp_zero, resp_err}, 0);
    check("rst_alu_ctrl", {alu_slt_sel, alu_main_sel, alu_sft_sel, alu_ryt_sft_sel,
                           alu_op, alu_sft_op}, 0);
    check("rst_alu_ops", {alu_a, alu_b}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_ready", instr_ready, 1);

    // Basic load and add
    issue(enc_li(3'd1, 9'd5));
    issue(enc_li(3'd2, 9'd3));
    issue(enc_r(4'd0, 3'd3, 3'd1, 3'd2));
    dbg_addr = 3'd3;
    @(negedge clk);
    check("add_r3_literal", dbg_data, 16'h0008);

    // Sub / slt / logic
    issue(enc_r(4'd1, 3'd4, 3'd1, 3'd2));
    issue(enc_r(4'd1, 3'd5, 3'd2, 3'd1));
    issue(enc_r(4'd4, 3'd6, 3'd2, 3'd1));
    issue(enc_r(4'd2, 3'd7, 3'd1, 3'd2));
    issue(enc_r(4'd3, 3'd0, 3'd1, 3'd2));

    // Shifts and sign-extended immediate
    issue(enc_li(3'd1, 9'd1));
    issue(enc_s(4'd5, 3'd1, 3'd1, 4'd15));
    issue(enc_s(4'd7, 3'd2, 3'd1, 4'd4));
    issue(enc_s(4'd6, 3'd3, 3'd1, 4'd4));
    issue(enc_li(3'd4, 9'h100));
    dbg_addr = 3'd2;
    @(negedge clk);
    check("sra_r2_literal", dbg_data, 16'hF800);

    // Back-pressure: second instruction waits for the first handshake
    predict(enc_r(4'd0, 3'd5, 3'd3, 3'd3));
    predict(enc_r(4'd1, 3'd6, 3'd5, 3'd3));
    accept(enc_r(4'd0, 3'd5, 3'd3, 3'd3));
    instr       = enc_r(4'd1, 3'd6, 3'd5, 3'd3);
    instr_valid = 1'b1;
    collect(5);
    accept(enc_r(4'd1, 3'd6, 3'd5, 3'd3));
    collect(0);
    check_reg(3'd6);

    // Illegal opcode leaves the register file untouched
    issue(16'hC000 | enc_r(4'd0, 3'd3, 3'd1, 3'd2));
    check_all_regs();

    // Reset during EXEC discards the instruction
    predict(enc_li(3'd7, 9'h0AA));
    accept(enc_li(3'd7, 9'h0AA));
    rst_n = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 8; i++) model_rf[i] = '0;
    #1;
    check("rst_exec_valid", resp_valid, 0);
    check("rst_exec_ready", instr_ready, 0);
    check("rst_exec_alu", {alu_a, alu_main_sel, alu_op}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_release_ready", instr_ready, 1);
    check("rst_release_valid", resp_valid, 0);
    check_all_regs();
    issue(enc_li(3'd2, 9'd7));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
